tmds_timing_param: RTL and testbench
====================================

Name: tmds_timing_param

Overview:
Parametrised successor to the fixed 720p TMDS receive timing recovery. It recovers active-video window, pixel/line counters and FIFO slice index from decoded hsync/vsync. Sync polarity is selectable at run time, and the block measures line/frame totals with a lock indicator. It sits between the TMDS decoder (rx0 channel) and the line FIFO / packetiser.

Parameters:
CW, 11, width of all h/v counters and video_hcnt/video_vcnt/h_total/v_total
IDX_W, 12, width of index
H_START, 219, hcounter value after which active pixels begin
H_ACTIVE, 1280, active pixels per line
V_START, 19, vcounter value after which active lines begin
V_ACTIVE, 720, active lines per frame
SLICE, 640, pixels per FIFO slice; H_ACTIVE must be a multiple of SLICE
LOCK_FRAMES, 3, consecutive identical frames required to assert locked

Ports:
rx0_pclk  in  1  pixel clock, sole clock
rstbtn_n  in  1  asynchronous active-high reset (despite the name)
rx0_hsync  in  1  raw hsync from decoder
rx0_vsync  in  1  raw vsync from decoder
hs_pol  in  1  1 = hsync active-high, 0 = active-low
vs_pol  in  1  1 = vsync active-high, 0 = active-low
video_en  out  1  active pixel window (hactive & vactive)
video_hcnt  out  CW  pixel number within active line
video_vcnt  out  CW  active line number
index  out  IDX_W  FIFO slice index
frame_start  out  1  one-cycle pulse on vsync assertion
h_total  out  CW  measured pclk cycles per line
v_total  out  CW  measured lines per frame
locked  out  1  timing stable

Behaviour:
- Reset (async, rstbtn_n=1): all registers and outputs 0; video_en=0, locked=0.
- hs = rx0_hsync XNOR hs_pol; vs = rx0_vsync XNOR vs_pol. hs_d/vs_d are 1-cycle registered copies; hs_rise = hs & ~hs_d, vs_rise = vs & ~vs_d.
- hcounter: 0 while hs, else +1, saturating at 2^CW-1.
- vcounter: 0 while vs; else +1 on hs_rise, saturating.
- hactive register: set the cycle after hcounter==H_START, cleared the cycle after hcounter==H_START+H_ACTIVE. This gives exactly H_ACTIVE cycles. vactive register uses the same rule with vcounter, V_START and V_ACTIVE. Clear has priority over set.
- video_en = hactive & vactive (combinational).
- video_hcnt: registered. 0 while !video_en, else +1. It reads 0..H_ACTIVE-1 aligned with video_en.
- video_vcnt: 0 while !vactive; +1 on hs_rise while vactive.
- index:
  - A slice counter (0..SLICE-1) runs during hactive.
  - At hcounter==H_START: index <= 0 if video_vcnt==0, else index+1.
  - At each later slice boundary (slice counter wraps to 0 and hactive is still 1): index+1.
  - The result is H_ACTIVE/SLICE increments per line. Wraps modulo 2^IDX_W.
- frame_start = vs_rise registered (1 cycle, one cycle after vs_rise).
- Measurement:
  - line_len counts pclk between hs_rise events and saturates. On hs_rise, h_total <= line_len+1 and line_len restarts at 0.
  - line_cnt counts hs_rise between vs_rise events. On vs_rise, v_total <= line_cnt and line_cnt restarts.
  - Saturation of line_len or line_cnt flags the period invalid.
- Lock:
  - match_cnt (0..LOCK_FRAMES) is updated on each vs_rise.
  - It increments if the new v_total equals the previous v_total, h_total was constant for every line of the frame, and no saturation occurred. Otherwise it resets to 0.
  - locked = (match_cnt==LOCK_FRAMES), and match_cnt holds at max.
  - Any mismatch drops locked on the cycle after that vs_rise.
  - An h_total change mid-frame marks the frame bad but does not drop locked until vs_rise.
- Polarity change mid-frame: counters follow new hs/vs immediately; lock typically lost at the next vs_rise.
- Simultaneous hs_rise and vs_rise: vcounter zeroes (vs wins), and the line still counts into line_cnt before the v_total latch.

Test Plan:
1. Default params, active-high 720p (1650x750, hsync 40, vsync 5) -> video_en high 1280 cycles/line × 720 lines; video_hcnt runs 0..1279; video_vcnt runs 0..719; index +2 per line, starting at 0 each frame.
2. Same timing with hs_pol=vs_pol=0 and inverted syncs -> identical outputs to scenario 1.
3. Three identical frames -> locked rises one cycle after the 3rd counted vs_rise; h_total=1650, v_total=750. A 4th frame with 751 lines -> locked=0 after that vs_rise.
4. Small params (H_START=3, H_ACTIVE=8, SLICE=4, V_START=1, V_ACTIVE=2) -> exact per-cycle check of hactive edges, index 0,1 on line 0 and 2,3 on line 1.
5. Hsync held inactive >2^CW cycles -> hcounter saturates, no spurious video_en, locked=0.
6. Assert rstbtn_n mid-active-line -> all outputs 0 immediately (asynchronous); normal recovery on the next frame.

Source files
------------

// File: rtl/tmds_timing_param.sv
// TMDS receive timing recovery: active window, pixel/line counters, FIFO slice index,
// plus measured line/frame totals with a stability (lock) indicator.
module tmds_timing_param #(
    parameter int CW          = 11,
    parameter int IDX_W       = 12,
    parameter int H_START     = 219,
    parameter int H_ACTIVE    = 1280,
    parameter int V_START     = 19,
    parameter int V_ACTIVE    = 720,
    parameter int SLICE       = 640,
    parameter int LOCK_FRAMES = 3
) (
    input  logic             rx0_pclk,
    input  logic             rstbtn_n,
    input  logic             rx0_hsync,
    input  logic             rx0_vsync,
    input  logic             hs_pol,
    input  logic             vs_pol,
    output logic             video_en,
    output logic [CW-1:0]    video_hcnt,
    output logic [CW-1:0]    video_vcnt,
    output logic [IDX_W-1:0] index,
    output logic             frame_start,
    output logic [CW-1:0]    h_total,
    output logic [CW-1:0]    v_total,
    output logic             locked
);

    localparam int SW = (SLICE > 1) ? $clog2(SLICE) : 1;
    localparam int MW = (LOCK_FRAMES > 0) ? $clog2(LOCK_FRAMES + 1) : 1;

    localparam logic [CW-1:0] CMAX   = '1;
    localparam logic [CW-1:0] H_ON   = CW'(H_START);
    localparam logic [CW-1:0] H_OFF  = CW'(H_START + H_ACTIVE);
    localparam logic [CW-1:0] V_ON   = CW'(V_START);
    localparam logic [CW-1:0] V_OFF  = CW'(V_START + V_ACTIVE);
    localparam logic [SW-1:0] S_LAST = SW'(SLICE - 1);
    localparam logic [MW-1:0] M_MAX  = MW'(LOCK_FRAMES);

    logic          hs, vs, hs_d, vs_d, hs_rise, vs_rise;
    logic [CW-1:0] hcounter, vcounter;
    logic          hactive, vactive;
    logic [SW-1:0] slice_cnt;
    logic [CW-1:0] line_len, line_cnt;
    logic [CW-1:0] h_new, v_new;
    logic          h_chg, sat_now, frame_bad, frame_ok;
    logic [MW-1:0] match_cnt;

    assign hs      = ~(rx0_hsync ^ hs_pol);
    assign vs      = ~(rx0_vsync ^ vs_pol);
    assign hs_rise = hs & ~hs_d;
    assign vs_rise = vs & ~vs_d;

    assign video_en = hactive & vactive;
    assign locked   = (match_cnt == M_MAX);

    // A line ending on this hs_rise also counts toward a frame ending on the same cycle
    assign h_new    = (line_len == CMAX) ? CMAX : line_len + 1'b1;
    assign v_new    = (hs_rise && line_cnt != CMAX) ? line_cnt + 1'b1 : line_cnt;
    assign h_chg    = hs_rise && (h_new != h_total);
    assign sat_now  = (line_len == CMAX) || (line_cnt == CMAX);
    assign frame_ok = !(frame_bad || h_chg || sat_now) && (v_new == v_total);

    // Sync edge detection and saturating raster counters
    always_ff @(posedge rx0_pclk or posedge rstbtn_n) begin
        if (rstbtn_n) begin
            hs_d        <= 1'b0;
            vs_d        <= 1'b0;
            hcounter    <= '0;
            vcounter    <= '0;
            frame_start <= 1'b0;
        end else begin
            hs_d        <= hs;
            vs_d        <= vs;
            frame_start <= vs_rise;
            if (hs)
                hcounter <= '0;
            else if (hcounter != CMAX)
                hcounter <= hcounter + 1'b1;
            if (vs)
                vcounter <= '0;
            else if (hs_rise && vcounter != CMAX)
                vcounter <= vcounter + 1'b1;
        end
    end

    // Active window flags and pixel/line numbering inside the window
    always_ff @(posedge rx0_pclk or posedge rstbtn_n) begin
        if (rstbtn_n) begin
            hactive    <= 1'b0;
            vactive    <= 1'b0;
            video_hcnt <= '0;
            video_vcnt <= '0;
        end else begin
            if (hcounter == H_OFF)
                hactive <= 1'b0;
            else if (hcounter == H_ON)
                hactive <= 1'b1;
            if (vcounter == V_OFF)
                vactive <= 1'b0;
            else if (vcounter == V_ON)
                vactive <= 1'b1;
            video_hcnt <= video_en ? video_hcnt + 1'b1 : '0;
            if (!vactive)
                video_vcnt <= '0;
            else if (hs_rise)
                video_vcnt <= video_vcnt + 1'b1;
        end
    end

    // FIFO slice index: restarts on the first active line, steps once per slice
    always_ff @(posedge rx0_pclk or posedge rstbtn_n) begin
        if (rstbtn_n) begin
            slice_cnt <= '0;
            index     <= '0;
        end else begin
            if (!hactive)
                slice_cnt <= '0;
            else
                slice_cnt <= (slice_cnt == S_LAST) ? '0 : slice_cnt + 1'b1;
            if (hcounter == H_ON)
                index <= (video_vcnt == '0) ? '0 : index + 1'b1;
            else if (hactive && slice_cnt == S_LAST && hcounter != H_OFF)
                index <= index + 1'b1;
        end
    end

    // Line/frame length measurement and lock qualification on each frame boundary
    always_ff @(posedge rx0_pclk or posedge rstbtn_n) begin
        if (rstbtn_n) begin
            line_len  <= '0;
            line_cnt  <= '0;
            h_total   <= '0;
            v_total   <= '0;
            frame_bad <= 1'b0;
            match_cnt <= '0;
        end else begin
            if (hs_rise) begin
                h_total  <= h_new;
                line_len <= '0;
            end else if (line_len != CMAX) begin
                line_len <= line_len + 1'b1;
            end
            if (vs_rise) begin
                v_total   <= v_new;
                line_cnt  <= '0;
                frame_bad <= 1'b0;
                if (!frame_ok)
                    match_cnt <= '0;
                else if (match_cnt != M_MAX)
                    match_cnt <= match_cnt + 1'b1;
            end else begin
                line_cnt  <= v_new;
                frame_bad <= frame_bad | h_chg | sat_now;
            end
        end
    end

endmodule

// File: tb/tb_tmds_timing_param.sv
// Bench for tmds_timing_param on a reduced raster: each cycle's expected outputs are
// derived from the raster position, queued when stimulus is driven, and checked at negedge.
module tb_tmds_timing_param;

    localparam int CW          = 6;
    localparam int IDX_W       = 12;
    localparam int H_START     = 3;
    localparam int H_ACTIVE    = 8;
    localparam int V_START     = 1;
    localparam int V_ACTIVE    = 2;
    localparam int SLICE       = 4;
    localparam int LOCK_FRAMES = 3;

    localparam int HT   = 16;
    localparam int HS   = 2;
    localparam int VT   = 6;
    localparam int VS   = 1;
    localparam int LONG = 90;
    localparam int CMAX = (1 << CW) - 1;
    localparam int P0   = HS + H_START + 1;
    localparam int L0   = VS + V_START - 1;

    logic             rx0_pclk;
    logic             rstbtn_n;
    logic             rx0_hsync;
    logic             rx0_vsync;
    logic             hs_pol;
    logic             vs_pol;
    logic             video_en;
    logic [CW-1:0]    video_hcnt;
    logic [CW-1:0]    video_vcnt;
    logic [IDX_W-1:0] index;
    logic             frame_start;
    logic [CW-1:0]    h_total;
    logic [CW-1:0]    v_total;
    logic             locked;

    tmds_timing_param #(
        .CW(CW), .IDX_W(IDX_W),
        .H_START(H_START), .H_ACTIVE(H_ACTIVE),
        .V_START(V_START), .V_ACTIVE(V_ACTIVE),
        .SLICE(SLICE), .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .rx0_pclk(rx0_pclk),
        .rstbtn_n(rstbtn_n),
        .rx0_hsync(rx0_hsync),
        .rx0_vsync(rx0_vsync),
        .hs_pol(hs_pol),
        .vs_pol(vs_pol),
        .video_en(video_en),
        .video_hcnt(video_hcnt),
        .video_vcnt(video_vcnt),
        .index(index),
        .frame_start(frame_start),
        .h_total(h_total),
        .v_total(v_total),
        .locked(locked)
    );

    typedef struct {
        bit en;
        int hcnt;
        int vcnt;
        int idx;
        bit fs;
        int ht;
        int vt;
        bit lk;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   exp_ht, exp_vt, prev_len, prev_vlines;
    bit   exp_lk;
    bit   inv;

    initial rx0_pclk = 1'b0;
    always #5 rx0_pclk = ~rx0_pclk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Restart expectations as seen right after a reset release.
    task automatic clear_model();
        exp_ht      = 0;
        exp_vt      = 0;
        prev_len    = 1;
        prev_vlines = 1;
        exp_lk      = 1'b0;
    endtask

    task automatic drive_sync(input bit h, input bit v);
        rx0_hsync = inv ? !h : h;
        rx0_vsync = inv ? !v : v;
        hs_pol    = !inv;
        vs_pol    = !inv;
    endtask

    // One pixel clock at raster position (l, p); entered and left at posedge+1.
    task automatic step(input int l, input int p, input bit lk_after);
        exp_t e;
        drive_sync(p < HS, l < VS);
        if (p == 1) begin
            exp_ht = (prev_len > CMAX) ? CMAX : prev_len;
            if (l == 0) begin
                exp_vt = (prev_vlines > CMAX) ? CMAX : prev_vlines;
                exp_lk = lk_after;
            end
        end
        e.en   = (l >= L0) && (l < L0 + V_ACTIVE) && (p >= P0) && (p < P0 + H_ACTIVE);
        e.hcnt = p - P0;
        e.vcnt = l - L0;
        e.idx  = (l - L0) * (H_ACTIVE / SLICE) + (p - P0) / SLICE;
        e.fs   = (l == 0) && (p == 1);
        e.ht   = exp_ht;
        e.vt   = exp_vt;
        e.lk   = exp_lk;
        sb.push_back(e);
        @(negedge rx0_pclk);
        e = sb.pop_front();
        cmp("video_en", video_en, e.en);
        if (e.en) begin
            cmp("video_hcnt", video_hcnt, e.hcnt);
            cmp("video_vcnt", video_vcnt, e.vcnt);
            cmp("index", index, e.idx);
        end
        cmp("frame_start", frame_start, e.fs);
        cmp("h_total", h_total, e.ht);
        cmp("v_total", v_total, e.vt);
        cmp("locked", locked, e.lk);
        @(posedge rx0_pclk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        cmp({tag, "_video_en"}, video_en, 0);
        cmp({tag, "_video_hcnt"}, video_hcnt, 0);
        cmp({tag, "_video_vcnt"}, video_vcnt, 0);
        cmp({tag, "_index"}, index, 0);
        cmp({tag, "_frame_start"}, frame_start, 0);
        cmp({tag, "_h_total"}, h_total, 0);
        cmp({tag, "_v_total"}, v_total, 0);
        cmp({tag, "_locked"}, locked, 0);
    endtask

    // Asynchronous reset in the middle of an active line.
    task automatic mid_reset();
        cmp("pre_reset_video_en", video_en, 1);
        #2;
        rstbtn_n = 1'b1;
        #1;
        check_zero("async");
        @(posedge rx0_pclk);
        #1;
        rstbtn_n = 1'b0;
        clear_model();
    endtask

    task automatic frame(input int nlines, input int long_line,
                         input bit lk_after, input int rst_line);
        int len;
        for (int l = 0; l < nlines; l++) begin
            len = (l == long_line) ? LONG : HT;
            for (int p = 0; p < len; p++) begin
                step(l, p, lk_after);
                if (l == rst_line && p == P0 + 2) begin
                    mid_reset();
                    return;
                end
            end
            prev_len = len;
        end
        prev_vlines = nlines;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        inv      = 1'b0;
        rstbtn_n = 1'b1;
        drive_sync(1'b0, 1'b0);
        clear_model();
        repeat (3) @(posedge rx0_pclk);
        @(negedge rx0_pclk);
        check_zero("reset");
        @(posedge rx0_pclk);
        #1;
        rstbtn_n = 1'b0;

        // Acquire lock: three good frames after the first full one.
        frame(VT, -1, 1'b0, -1);
        frame(VT, -1, 1'b0, -1);
        frame(VT, -1, 1'b0, -1);
        frame(VT, -1, 1'b0, -1);
        frame(VT, -1, 1'b1, -1);

        // Same logical timing, inverted polarity and raw syncs.
        inv = 1'b1;
        frame(VT, -1, 1'b1, -1);
        frame(VT, -1, 1'b1, -1);
        inv = 1'b0;

        // Overlong line saturates the counters and spoils the frame.
        frame(VT, 1, 1'b1, -1);
        frame(VT, -1, 1'b0, -1);
        frame(VT, -1, 1'b0, -1);
        frame(VT, -1, 1'b0, -1);

        // Relock, then a frame one line longer drops it.
        frame(VT + 1, -1, 1'b1, -1);
        frame(VT, -1, 1'b0, -1);

        // Reset mid active line, then recover on the following frames.
        frame(VT, -1, 1'b0, L0 + 1);
        frame(VT, -1, 1'b0, -1);
        frame(VT, -1, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
